// File: rtl/seq_divider.sv
// Multi-cycle restoring radix-2 unsigned divider with valid/ready handshakes.
// One quotient bit per cycle; divide-by-zero short-circuits straight to DONE.
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  // dividend bits leave at the MSB while quotient bits enter at the LSB
  logic [DIVIDEND_W-1:0]   work_sr_r;
  logic [DIVISOR_W-1:0]    divisor_r;
  logic [DIVISOR_W-1:0]    rem_r;
  logic [CNT_W-1:0]        count_r;
  logic [DIVIDEND_W-1:0]   quotient_r;
  logic [DIVISOR_W-1:0]    remainder_r;
  logic                    dbz_r;
  logic                    in_ready_r;
  logic                    out_valid_r;

  logic [DIVISOR_W:0]      rem_shift_s;
  logic [DIVISOR_W-1:0]    rem_next_s;
  logic                    quot_bit_s;

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

  // Next-state logic for the IDLE/DIV/DONE controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (divisor == {DIVISOR_W{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = DIV;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        if (count_r == CNT_ONE) begin
          state_s = DONE;
        end else begin
          state_s = DIV;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // One restoring step; r < divisor keeps the difference inside DIVISOR_W bits.
  always_comb begin
    rem_shift_s = {rem_r, work_sr_r[DIVIDEND_W-1]};
    quot_bit_s  = 1'b0;
    rem_next_s  = rem_shift_s[DIVISOR_W-1:0];
    if (rem_shift_s >= {1'b0, divisor_r}) begin
      quot_bit_s = 1'b1;
      rem_next_s = rem_shift_s[DIVISOR_W-1:0] - divisor_r;
    end else begin
      quot_bit_s = 1'b0;
      rem_next_s = rem_shift_s[DIVISOR_W-1:0];
    end
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      work_sr_r   <= {DIVIDEND_W{1'b0}};
      divisor_r   <= {DIVISOR_W{1'b0}};
      rem_r       <= {DIVISOR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      quotient_r  <= {DIVIDEND_W{1'b0}};
      remainder_r <= {DIVISOR_W{1'b0}};
      dbz_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_sr_r <= dividend;
            divisor_r <= divisor;
            rem_r     <= {DIVISOR_W{1'b0}};
            count_r   <= CNT_INIT;
            if (divisor == {DIVISOR_W{1'b0}}) begin
              quotient_r  <= {DIVIDEND_W{1'b1}};
              remainder_r <= {DIVISOR_W{1'b0}};
              dbz_r       <= 1'b1;
            end else begin
              quotient_r  <= {DIVIDEND_W{1'b0}};
              remainder_r <= {DIVISOR_W{1'b0}};
              dbz_r       <= 1'b0;
            end
          end
        end
        DIV: begin
          work_sr_r <= {work_sr_r[DIVIDEND_W-2:0], quot_bit_s};
          rem_r     <= rem_next_s;
          count_r   <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            quotient_r  <= {work_sr_r[DIVIDEND_W-2:0], quot_bit_s};
            remainder_r <= rem_next_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases, backpressure, mid-operation
// reset and an exhaustive randomized-stall sweep against integer / and %.
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dbz;
    int t0;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   ready_mode  = 1'b0;
  bit   ready_force = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // edge counter: value after edge k is k
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready driver: forced level or random stalls
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: checks every cycle a result is presented; pops on the handshake.
  initial begin
    bit prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        check("in_ready_low_while_valid", int'(in_ready), 0);
        check("result_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          if (!prev_ov) check("latency_edges", cyc - exp_q[0].t0, exp_q[0].lat);
          check("quotient", int'(quotient), exp_q[0].q);
          check("remainder", int'(remainder), exp_q[0].r);
          check("div_by_zero", int'(div_by_zero), exp_q[0].dbz);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // Present operands until accepted; the reference result is pushed at acceptance.
  task automatic issue(input int a, input int b);
    int   waited;
    bit   done;
    exp_t e;
    waited = 0;
    done = 1'b0;
    dividend = DW'(a);
    divisor  = VW'(b);
    in_valid = 1'b1;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        e.q   = (b == 0) ? 255 : a / b;
        e.r   = (b == 0) ? 0 : a % b;
        e.dbz = (b == 0) ? 1 : 0;
        e.t0  = cyc + 1;
        // a normal divide finishes DW edges after acceptance; divide-by-zero
        // enters DONE on the accepting edge, so out_valid is up the very next cycle
        e.lat = (b == 0) ? 0 : DW;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    check("operand_accepted", int'(done), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("results_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int da[6] = '{200, 255, 5, 0, 13, 9};
    int db[6] = '{7, 15, 9, 3, 0, 2};
    int n;
    int seen;

    rst = 1'b1;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);

    // directed operands, consumer always ready
    @(posedge clk);
    #1;
    foreach (da[i]) issue(da[i], db[i]);
    drain();

    // backpressure: hold the result while a new operand is ignored
    ready_force = 1'b0;
    issue(100, 6);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_out_valid", int'(out_valid), 1);
    in_valid = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd3;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_hold_quotient", int'(quotient), 16);
      check("bp_hold_remainder", int'(remainder), 4);
    end
    ready_force = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // reset sampled on the edge ending the 4th DIV cycle of 77/5
    issue(77, 5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midop_rst_in_ready", int'(in_ready), 1);
    check("midop_rst_out_valid", int'(out_valid), 0);
    check("midop_rst_quotient", int'(quotient), 0);
    check("midop_rst_remainder", int'(remainder), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midop_rst_no_result", seen, 0);
    @(posedge clk);
    #1;
    issue(77, 5);
    drain();

    // exhaustive sweep with random input gaps and output stalls
    ready_mode = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 1) != 0) begin
          @(posedge clk);
          #1;
        end
        issue(a, b);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
